conv_layer_sched: RTL and testbench

Top-level layer scheduler for the CNN accelerator. Sequences the convolution engine (kernel 0, then kernel 1), the max-pool engine (per kernel) and the flatten engine through start/done handshakes. It multiplexes their memory requests onto the single shared layer-memory port (`cwr`/`crd`/`caddr_*`/`cdata_wr`/`csel`). It owns the testbench-facing `ready`/`busy` handshake.

---
 rtl/conv_layer_sched.sv | 170 +++++++++++++++++
 tb/tb_conv_layer_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// Layer scheduler: runs conv k0/k1, pool k0/k1 and flatten in order through start/done
// handshakes, and muxes the active engine's requests onto the shared layer-memory port.
module conv_layer_sched #(
  parameter int                WDOG_W     = 20,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  output logic        busy,
  output logic        err,
  output logic        conv_start,
  output logic        conv_ksel,
  input  logic        conv_done,
  output logic        pool_start,
  output logic        pool_ksel,
  input  logic        pool_done,
  output logic        flat_start,
  input  logic        flat_done,
  input  logic        conv_cwr,
  input  logic [11:0] conv_caddr_wr,
  input  logic [19:0] conv_cdata_wr,
  input  logic        pool_crd,
  input  logic [11:0] pool_caddr_rd,
  input  logic        pool_cwr,
  input  logic [11:0] pool_caddr_wr,
  input  logic [19:0] pool_cdata_wr,
  input  logic        flat_crd,
  input  logic        flat_rsel,
  input  logic [11:0] flat_caddr_rd,
  input  logic        flat_cwr,
  input  logic [11:0] flat_caddr_wr,
  input  logic [19:0] flat_cdata_wr,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic        crd,
  output logic [11:0] caddr_rd,
  output logic [2:0]  csel
);

  typedef enum logic [3:0] {
    IDLE, C0_GO, C0_RUN, C1_GO, C1_RUN, P0_GO, P0_RUN,
    P1_GO, P1_RUN, F_GO, F_RUN, DONE
  } state_t;

  state_t            state, next_state;
  logic [WDOG_W-1:0] wdog;
  logic              run, go, wdog_exp, coll;
  logic              act_done, act_rd, act_wr;
  logic [11:0]       act_aw, act_ar;
  logic [19:0]       act_wd;
  logic [2:0]        wsel, rsel;

  assign run = (state == C0_RUN) || (state == C1_RUN) || (state == P0_RUN) ||
               (state == P1_RUN) || (state == F_RUN);
  assign go  = (state == C0_GO) || (state == C1_GO) || (state == P0_GO) ||
               (state == P1_GO) || (state == F_GO);

  // Decode of the engine that owns the port; everything stays 0 outside RUN states.
  always_comb begin
    act_done = 1'b0;
    act_rd   = 1'b0;
    act_wr   = 1'b0;
    act_aw   = '0;
    act_ar   = '0;
    act_wd   = '0;
    wsel     = 3'd0;
    rsel     = 3'd0;
    case (state)
      C0_RUN, C1_RUN: begin
        act_done = conv_done;
        act_wr   = conv_cwr;
        act_aw   = conv_caddr_wr;
        act_wd   = conv_cdata_wr;
        wsel     = (state == C0_RUN) ? 3'd1 : 3'd2;
      end
      P0_RUN, P1_RUN: begin
        act_done = pool_done;
        act_rd   = pool_crd;
        act_wr   = pool_cwr;
        act_ar   = pool_caddr_rd;
        act_aw   = pool_caddr_wr;
        act_wd   = pool_cdata_wr;
        wsel     = (state == P0_RUN) ? 3'd3 : 3'd4;
        rsel     = (state == P0_RUN) ? 3'd1 : 3'd2;
      end
      F_RUN: begin
        act_done = flat_done;
        act_rd   = flat_crd;
        act_wr   = flat_cwr;
        act_ar   = flat_caddr_rd;
        act_aw   = flat_caddr_wr;
        act_wd   = flat_cdata_wr;
        wsel     = 3'd5;
        rsel     = flat_rsel ? 3'd4 : 3'd3;
      end
      default: ;
    endcase
  end

  assign coll     = act_rd & act_wr;
  assign wdog_exp = run & ~act_done & (wdog == WDOG_LIMIT - 1'b1);

  // State register and watchdog
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= next_state;
      if (go)       wdog <= '0;
      else if (run) wdog <= wdog + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (ready) next_state = C0_GO;
      C0_GO:  next_state = C0_RUN;
      C1_GO:  next_state = C1_RUN;
      P0_GO:  next_state = P0_RUN;
      P1_GO:  next_state = P1_RUN;
      F_GO:   next_state = F_RUN;
      C0_RUN: if (act_done) next_state = C1_GO; else if (wdog_exp) next_state = DONE;
      C1_RUN: if (act_done) next_state = P0_GO; else if (wdog_exp) next_state = DONE;
      P0_RUN: if (act_done) next_state = P1_GO; else if (wdog_exp) next_state = DONE;
      P1_RUN: if (act_done) next_state = F_GO;  else if (wdog_exp) next_state = DONE;
      F_RUN:  if (act_done || wdog_exp) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered handshake outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      err        <= 1'b0;
      conv_start <= 1'b0;
      conv_ksel  <= 1'b0;
      pool_start <= 1'b0;
      pool_ksel  <= 1'b0;
      flat_start <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      err        <= err | wdog_exp | coll;
      conv_start <= (next_state == C0_GO) || (next_state == C1_GO);
      pool_start <= (next_state == P0_GO) || (next_state == P1_GO);
      flat_start <= (next_state == F_GO);
      if (next_state == C0_GO)      conv_ksel <= 1'b0;
      else if (next_state == C1_GO) conv_ksel <= 1'b1;
      if (next_state == P0_GO)      pool_ksel <= 1'b0;
      else if (next_state == P1_GO) pool_ksel <= 1'b1;
    end
  end

  // Shared port: a write beats a simultaneous read
  always_comb begin
    cwr      = act_wr;
    crd      = act_rd & ~act_wr;
    caddr_wr = act_wr ? act_aw : 12'd0;
    cdata_wr = act_wr ? act_wd : 20'd0;
    caddr_rd = (act_rd & ~act_wr) ? act_ar : 12'd0;
    csel     = act_wr ? wsel : (act_rd ? rsel : 3'd0);
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: phase/step reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak with random resets.
module tb_conv_layer_sched;
  localparam int LIM = 100;

  logic clk = 0, reset_n = 0, ready = 0;
  logic conv_done = 0, pool_done = 0, flat_done = 0;
  logic conv_cwr = 0, pool_crd = 0, pool_cwr = 0, flat_crd = 0, flat_rsel = 0, flat_cwr = 0;
  logic [11:0] conv_caddr_wr = 0, pool_caddr_rd = 0, pool_caddr_wr = 0;
  logic [11:0] flat_caddr_rd = 0, flat_caddr_wr = 0;
  logic [19:0] conv_cdata_wr = 0, pool_cdata_wr = 0, flat_cdata_wr = 0;
  logic busy, err, conv_start, conv_ksel, pool_start, pool_ksel, flat_start;
  logic cwr, crd;
  logic [11:0] caddr_wr, caddr_rd;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  conv_layer_sched #(.WDOG_W(20), .WDOG_LIMIT(20'(LIM))) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .busy(busy), .err(err),
    .conv_start(conv_start), .conv_ksel(conv_ksel), .conv_done(conv_done),
    .pool_start(pool_start), .pool_ksel(pool_ksel), .pool_done(pool_done),
    .flat_start(flat_start), .flat_done(flat_done),
    .conv_cwr(conv_cwr), .conv_caddr_wr(conv_caddr_wr), .conv_cdata_wr(conv_cdata_wr),
    .pool_crd(pool_crd), .pool_caddr_rd(pool_caddr_rd), .pool_cwr(pool_cwr),
    .pool_caddr_wr(pool_caddr_wr), .pool_cdata_wr(pool_cdata_wr),
    .flat_crd(flat_crd), .flat_rsel(flat_rsel), .flat_caddr_rd(flat_caddr_rd),
    .flat_cwr(flat_cwr), .flat_caddr_wr(flat_caddr_wr), .flat_cdata_wr(flat_cdata_wr),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
    .caddr_rd(caddr_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pass = 5 jobs (k = 0..4); each job is one GO step then RUN steps.
  int m_stage, m_k, m_runs;   // stage 0 idle, 1 go, 2 run, 3 done
  logic m_err, m_cksel, m_pksel;
  int WSEL[5] = '{1, 2, 3, 4, 5};
  int RSEL[5] = '{0, 0, 1, 2, 3};

  function automatic logic eng_done(int k);
    return (k < 2) ? conv_done : (k < 4) ? pool_done : flat_done;
  endfunction
  function automatic logic eng_wr(int k);
    return (k < 2) ? conv_cwr : (k < 4) ? pool_cwr : flat_cwr;
  endfunction
  function automatic logic eng_rd(int k);
    return (k < 2) ? 1'b0 : (k < 4) ? pool_crd : flat_crd;
  endfunction
  function automatic logic [11:0] eng_aw(int k);
    return (k < 2) ? conv_caddr_wr : (k < 4) ? pool_caddr_wr : flat_caddr_wr;
  endfunction
  function automatic logic [11:0] eng_ar(int k);
    return (k < 4) ? pool_caddr_rd : flat_caddr_rd;
  endfunction
  function automatic logic [19:0] eng_wd(int k);
    return (k < 2) ? conv_cdata_wr : (k < 4) ? pool_cdata_wr : flat_cdata_wr;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stage <= 0; m_k <= 0; m_runs <= 0; m_err <= 0; m_cksel <= 0; m_pksel <= 0;
    end else begin
      case (m_stage)
        0: if (ready) begin m_stage <= 1; m_k <= 0; m_cksel <= 0; end
        1: begin m_stage <= 2; m_runs <= 0; end
        2: begin
          m_runs <= m_runs + 1;
          if (eng_rd(m_k) && eng_wr(m_k)) m_err <= 1;
          if (eng_done(m_k)) begin
            if (m_k == 4) m_stage <= 3;
            else begin
              m_stage <= 1; m_k <= m_k + 1;
              if (m_k == 0) m_cksel <= 1;
              if (m_k == 1) m_pksel <= 0;
              if (m_k == 2) m_pksel <= 1;
            end
          end else if (m_runs + 1 == LIM) begin
            m_err <= 1; m_stage <= 3;
          end
        end
        default: m_stage <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    automatic logic e_cwr = 0, e_crd = 0;
    automatic logic [11:0] e_aw = 0, e_ar = 0;
    automatic logic [19:0] e_wd = 0;
    automatic int e_sel = 0;
    if (m_stage == 2) begin
      if (eng_wr(m_k)) begin
        e_cwr = 1; e_aw = eng_aw(m_k); e_wd = eng_wd(m_k); e_sel = WSEL[m_k];
      end else if (eng_rd(m_k)) begin
        e_crd = 1; e_ar = eng_ar(m_k);
        e_sel = (m_k == 4) ? 3 + int'(flat_rsel) : RSEL[m_k];
      end
    end
    chk("busy", busy, m_stage != 0);
    chk("err", err, m_err);
    chk("conv_start", conv_start, m_stage == 1 && m_k < 2);
    chk("pool_start", pool_start, m_stage == 1 && (m_k == 2 || m_k == 3));
    chk("flat_start", flat_start, m_stage == 1 && m_k == 4);
    chk("conv_ksel", conv_ksel, m_cksel);
    chk("pool_ksel", pool_ksel, m_pksel);
    chk("port", {cwr, crd, caddr_wr, caddr_rd, csel}, {e_cwr, e_crd, e_aw, e_ar, 3'(e_sel)});
    chk("cdata_wr", cdata_wr, e_wd);
  end

  // Engine responders: done pulses dly cycles after the start cycle.
  bit rnd = 0, hold_pool = 0;
  int dly = 10, c_cnt = 0, p_cnt = 0, f_cnt = 0;
  function automatic int pick_dly();
    return rnd ? int'($urandom_range(1, 12)) : dly;
  endfunction

  initial forever begin
    @(posedge clk); #1;
    conv_done = 0; pool_done = 0; flat_done = 0;
    if (!reset_n) begin
      c_cnt = 0; p_cnt = 0; f_cnt = 0;
    end else begin
      if (c_cnt > 0) begin c_cnt--; if (c_cnt == 0) conv_done = 1; end
      if (p_cnt > 0) begin p_cnt--; if (p_cnt == 0 && !hold_pool) pool_done = 1; end
      if (f_cnt > 0) begin f_cnt--; if (f_cnt == 0) flat_done = 1; end
      if (conv_start) c_cnt = pick_dly();
      if (pool_start) p_cnt = pick_dly();
      if (flat_start) f_cnt = pick_dly();
    end
    if (rnd) begin
      if ($urandom_range(0, 15) == 0) conv_done = 1;
      if ($urandom_range(0, 15) == 0) pool_done = 1;
      if ($urandom_range(0, 15) == 0) flat_done = 1;
      ready = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      conv_cwr = ($urandom_range(0, 2) == 0); conv_caddr_wr = 12'($urandom); conv_cdata_wr = 20'($urandom);
      pool_crd = ($urandom_range(0, 2) == 0); pool_caddr_rd = 12'($urandom);
      pool_cwr = ($urandom_range(0, 3) == 0); pool_caddr_wr = 12'($urandom); pool_cdata_wr = 20'($urandom);
      flat_crd = ($urandom_range(0, 2) == 0); flat_rsel = 1'($urandom); flat_caddr_rd = 12'($urandom);
      flat_cwr = ($urandom_range(0, 3) == 0); flat_caddr_wr = 12'($urandom); flat_cdata_wr = 20'($urandom);
    end
  end

  task automatic clr_mem();
    conv_cwr = 0; pool_crd = 0; pool_cwr = 0; flat_crd = 0; flat_cwr = 0; flat_rsel = 0;
    conv_caddr_wr = 0; conv_cdata_wr = 0; pool_caddr_rd = 0; pool_caddr_wr = 0;
    pool_cdata_wr = 0; flat_caddr_rd = 0; flat_caddr_wr = 0; flat_cdata_wr = 0;
  endtask

  task automatic kick();
    @(posedge clk); #2 ready = 1;
    @(posedge clk); #2 ready = 0;
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
  endtask

  // Wait (at negedge) for a start pulse: which 0 conv, 1 pool, 2 flat, with given ksel.
  task automatic wait_start(string name, int which, logic ks);
    automatic bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = conv_start && conv_ksel == ks;
        1: hit = pool_start && pool_ksel == ks;
        default: hit = flat_start;
      endcase
    end
    chk({name, "_seen"}, hit, 1);
  endtask

  task automatic wait_idle(string name);
    automatic bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin @(negedge clk); hit = !busy; end
    chk({name, "_idle"}, hit, 1);
  endtask

  initial begin
    automatic int seq[$];
    automatic int exp_seq[5] = '{0, 1, 2, 3, 4};
    automatic int n;
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("rst_state", {busy, err, conv_start, pool_start, flat_start, conv_ksel, pool_ksel, cwr, crd, csel}, 0);

    // Plain pass: ordering and busy length
    kick();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (conv_start) seq.push_back(int'(conv_ksel));
      if (pool_start) seq.push_back(2 + int'(pool_ksel));
      if (flat_start) seq.push_back(4);
      if (busy) n++;
      else if (n > 0) break;
    end
    chk("busy_cycles", n, 56);
    chk("start_count", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("start_order", seq[i], exp_seq[i]);
    chk("pass1_err", err, 0);

    // Conv kernel-1 write routing
    kick();
    wait_start("c1", 0, 1'b1);
    @(posedge clk); #2 conv_cwr = 1; conv_caddr_wr = 12'h0FF; conv_cdata_wr = 20'h12345;
    #1 chk("c1_wr", {cwr, csel, caddr_wr, cdata_wr}, {1'b1, 3'd2, 12'h0FF, 20'h12345});
    @(posedge clk); #2 clr_mem();
    // Flatten reads on both banks, then a write
    wait_start("f", 2, 1'b0);
    @(posedge clk); #2 flat_crd = 1; flat_caddr_rd = 12'h00A; flat_rsel = 0;
    #1 chk("f_rd0", {crd, csel, caddr_rd}, {1'b1, 3'd3, 12'h00A});
    @(posedge clk); #2 flat_rsel = 1;
    #1 chk("f_rd1", {crd, csel, caddr_rd}, {1'b1, 3'd4, 12'h00A});
    @(posedge clk); #2 flat_rsel = 0;
    #1 chk("f_rd2", {crd, csel}, {1'b1, 3'd3});
    @(posedge clk); #2 flat_crd = 0; flat_cwr = 1; flat_caddr_wr = 12'h00A; flat_cdata_wr = 20'h5;
    #1 chk("f_wr", {cwr, crd, csel, caddr_wr, cdata_wr}, {1'b1, 1'b0, 3'd5, 12'h00A, 20'h5});
    @(posedge clk); #2 clr_mem();
    wait_idle("p2");
    chk("p2_err", err, 0);

    // Read/write collision in P0_RUN
    kick();
    wait_start("p0", 1, 1'b0);
    @(posedge clk); #2 pool_crd = 1; pool_cwr = 1; pool_caddr_rd = 12'h011;
    pool_caddr_wr = 12'h022; pool_cdata_wr = 20'h3;
    #1 chk("coll_port", {cwr, crd, csel, caddr_rd, caddr_wr}, {1'b1, 1'b0, 3'd3, 12'h000, 12'h022});
    chk("coll_err_pre", err, 0);
    @(posedge clk); #2 clr_mem();
    chk("coll_err_post", err, 1);
    wait_start("coll_flat", 2, 1'b0);
    wait_idle("coll");
    chk("coll_err_sticky", err, 1);
    do_reset();

    // Watchdog on a withheld pool done
    hold_pool = 1;
    kick();
    wait_start("wd", 1, 1'b0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pool_start) chk("wd_no_p1", pool_start, 0);
      if (!busy) break;
      n++;
    end
    chk("wd_cycles", n, LIM + 1);
    chk("wd_err", err, 1);
    hold_pool = 0;
    do_reset();

    // Asynchronous reset during C0_RUN
    kick();
    wait_start("r", 0, 1'b0);
    @(posedge clk); #2 conv_cwr = 1; conv_caddr_wr = 12'h123; conv_cdata_wr = 20'hABCDE;
    #1 chk("r_pre", {busy, cwr, csel}, {1'b1, 1'b1, 3'd1});
    #1 reset_n = 0;
    #1 chk("r_async", {busy, err, conv_start, conv_ksel, cwr, crd, csel, caddr_wr, cdata_wr}, 0);
    @(posedge clk); #2 clr_mem(); reset_n = 1;
    kick();
    wait_start("r_restart", 0, 1'b0);
    wait_idle("r_restart");

    // Randomized soak
    rnd = 1;
    repeat (4000) @(posedge clk);
    rnd = 0;
    #3 reset_n = 1; ready = 0; clr_mem();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
